decode_l: RTL
=============

Name: decode_l

Overview:
- Receive-side counterpart of the level-modulated light link.
- Takes the measured light level `l_meas` (0..0x1F4 scale, same as the transmit level) and slices it into a bit stream using a hysteresis window around `l_def`.
- Recovers framed bytes (start, 8 data LSB-first, stop) by mid-bit sampling.
- Sits between the photodiode ADC front end and the receive data buffer; active only while receiving.

Parameters:
- BIT_CYC, 20'h6000, clock cycles per bit period (minimum 4, even).
- HYST, 12'd50, half-width of the slicer hysteresis window around `l_def`.
- LMAX, 12'h1F4, full-scale level; the upper threshold saturates here.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- nrst  input  1  synchronous reset, active-high (1 = reset).
- data_start  input  1  link session active.
- data_rec  input  1  receive mode; block enabled when `data_start && data_rec`.
- l_def  input  12  nominal mid level used as slicer centre.
- l_meas  input  12  measured light level, new sample every cycle.
- d  output  1  sliced bit (registered).
- data_byte  output  8  last received byte.
- byte_valid  output  1  one-cycle strobe, `data_byte` updated.
- frame_err  output  1  one-cycle strobe on bad stop bit or false start.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (`nrst = 1` at a clock edge) values:
  - `d` = 0, `data_byte` = 0, `byte_valid` = 0, `frame_err` = 0, `rx_busy` = 0.
  - FSM = IDLE, bit counter = 0, cycle counter = 0.
  - Reset mid-frame discards the partial byte with no strobe.
- Input stage: `l_meas` registered once (`l_q`), giving 1 cycle latency to the slicer.
- Thresholds (computed combinationally, unsigned, 13-bit intermediate):
  - `th_hi = min(l_def + HYST, LMAX)`.
  - `th_lo = (l_def > HYST) ? l_def - HYST : 0`.
- Slicer, registered into `d`:
  - `l_q >= th_hi` → `d` = 1.
  - `l_q <= th_lo` → `d` = 0.
  - Otherwise `d` holds.
  - If `th_lo >= th_hi` (degenerate `l_def`), the `d = 1` rule wins.
  - Total latency `l_meas` → `d` is 2 cycles.
- Enable: when `data_start && data_rec` = 0, `d` is forced to 0, FSM is forced to IDLE, counters are cleared, and no strobes are produced. Disabling mid-frame aborts silently.
- FSM states IDLE, START, DATA, STOP, using cycle counter `cnt` (20 bit) and bit index `bi` (3 bit):
  - IDLE: on `d` 0→1 (previous `d` registered) → START, `cnt` = 0.
  - START: `cnt` increments. At `cnt == BIT_CYC/2 - 1`:
    - `d == 1` → DATA, `cnt` = 0, `bi` = 0.
    - else pulse `frame_err` → IDLE.
  - DATA: `cnt` increments. At `cnt == BIT_CYC - 1`: shift `d` into `shift[bi]` (LSB first), `cnt` = 0, `bi` += 1. After `bi == 7` is sampled → STOP.
  - STOP: at `cnt == BIT_CYC - 1`:
    - `d == 0` → `data_byte` = shift, pulse `byte_valid`.
    - else pulse `frame_err`, `data_byte` unchanged.
    - Either way → IDLE.
  - A new rising edge is accepted in the cycle after returning to IDLE. Back-to-back frames separated by one full stop bit must decode.
- Strobes: `byte_valid` and `frame_err` are exactly 1 cycle wide and never both high in the same cycle.
- `rx_busy` = (state != IDLE), registered with the state.
- Counter wrap: `cnt` never exceeds `BIT_CYC - 1`. `bi` wraps 7→0 only on the DATA→STOP transition.

Test Plan:
- Reset: hold `nrst = 1` for 3 cycles with `l_meas = 0x1F4`, enable high → all outputs 0, `rx_busy` 0. First `d` = 1 appears 2 cycles after release.
- Hysteresis: `l_def = 250`, `HYST = 50`. Sweep `l_meas` 200→300→260→199:
  - `d` = 0 at 200, 1 at 300, 1 at 260 (hold), 0 at 199.
  - Each change lags the input by 2 cycles.
- Byte decode: `BIT_CYC = 16`, `l_def = 250`. Send start (500), bits of 0xA5 LSB first (500 for 1, 0 for 0), stop (0) → single `byte_valid`, `data_byte` = 0xA5, no `frame_err`.
- Framing errors:
  - Same frame with stop level 500 → `frame_err` pulse, `data_byte` keeps the previous value.
  - A 4-cycle glitch to 500 from idle → `frame_err` at mid-start, back to IDLE.
- Saturation: `l_def = 480`, so `th_hi` = 500. `l_meas` = 500 → `d` = 1; `l_meas` = 499 from 0 → `d` stays 0.
- Abort/back-to-back:
  - Drop `data_rec` during bit 3 → IDLE next cycle, no strobe.
  - Two consecutive frames 0x3C, 0xFF → two `byte_valid` strobes exactly `10*BIT_CYC` apart.

Source files
------------

// File: rtl/decode_l.sv
// Receive slicer and UART-style deframer for the level-modulated light link.
// Hysteresis slicing of the measured level, then mid-bit sampling of start/8 data/stop.
module decode_l #(
   parameter logic [19:0] BIT_CYC = 20'h6000,
   parameter logic [11:0] HYST    = 12'd50,
   parameter logic [11:0] LMAX    = 12'h1F4
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        data_start,
   input  logic        data_rec,
   input  logic [11:0] l_def,
   input  logic [11:0] l_meas,
   output logic        d,
   output logic [7:0]  data_byte,
   output logic        byte_valid,
   output logic        frame_err,
   output logic        rx_busy
);

   localparam logic [19:0] HALF_M1 = (BIT_CYC >> 1) - 20'd1;
   localparam logic [19:0] FULL_M1 = BIT_CYC - 20'd1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state;
   logic [11:0] l_q;
   logic        d_prev;
   logic [19:0] cnt;
   logic [2:0]  bi;
   logic [7:0]  shift;

   logic        en_c;
   logic [12:0] sum_hi_c;
   logic [11:0] th_hi_c;
   logic [11:0] th_lo_c;
   logic        d_nxt_c;

   assign en_c = data_start && data_rec;

   // Hysteresis window; upper edge saturates at full scale, lower edge floors at 0.
   always_comb begin
      sum_hi_c = 13'(l_def) + 13'(HYST);
      th_hi_c  = (sum_hi_c > 13'(LMAX)) ? LMAX : sum_hi_c[11:0];
      th_lo_c  = (l_def > HYST) ? 12'(l_def - HYST) : 12'd0;
      d_nxt_c  = d;
      if (l_q >= th_hi_c)
         d_nxt_c = 1'b1;
      else if (l_q <= th_lo_c)
         d_nxt_c = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         l_q        <= '0;
         d          <= 1'b0;
         d_prev     <= 1'b0;
         state      <= IDLE;
         cnt        <= '0;
         bi         <= '0;
         shift      <= '0;
         data_byte  <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         rx_busy    <= 1'b0;
      end else begin
         l_q        <= l_meas;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (!en_c) begin
            // Disabled: silent abort, slicer output parked low.
            d       <= 1'b0;
            d_prev  <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
            bi      <= '0;
            rx_busy <= 1'b0;
         end else begin
            d      <= d_nxt_c;
            d_prev <= d;
            case (state)
               IDLE: begin
                  if (d && !d_prev) begin
                     state   <= START;
                     cnt     <= '0;
                     rx_busy <= 1'b1;
                  end
               end
               START: begin
                  if (cnt == HALF_M1) begin
                     cnt <= '0;
                     if (d) begin
                        state <= DATA;
                        bi    <= '0;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        rx_busy   <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt + 20'd1;
                  end
               end
               DATA: begin
                  if (cnt == FULL_M1) begin
                     shift[bi] <= d;
                     cnt       <= '0;
                     bi        <= 3'(bi + 3'd1);
                     if (bi == 3'd7)
                        state <= STOP;
                  end else begin
                     cnt <= cnt + 20'd1;
                  end
               end
               STOP: begin
                  if (cnt == FULL_M1) begin
                     cnt     <= '0;
                     state   <= IDLE;
                     rx_busy <= 1'b0;
                     if (!d) begin
                        data_byte  <= shift;
                        byte_valid <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 20'd1;
                  end
               end
               default: begin
                  state   <= IDLE;
                  rx_busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
